// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared constants and types for the round-robin arbitrating mux.
// Optional feature macro: ARB_LOCK_EN (packet lock; see rr_arb_mux.sv).
package rr_arb_mux_pkg;

    // Channel-selection mode as presented on the mode input.
    typedef enum logic {
        MODE_RR  = 1'b0,
        MODE_SEL = 1'b1
    } mode_e;

    // Packet-lock state of the round-robin arbiter.
    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_e;

    localparam int unsigned DEF_N_CH = 4;
    localparam int unsigned DEF_W    = 8;

    // Next channel index after k, wrapping n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
        return (k + 32'd1 >= n) ? 32'd0 : k + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer/consumer side handshake bundle of rr_arb_mux.
// in_last exists only when ARB_LOCK_EN is defined.
interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned W    = DEF_W
) ();

    localparam int unsigned SEL_W = $clog2(N_CH);

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH*W-1:0]    in_data;
    logic [N_CH-1:0]      in_ready;
`ifdef ARB_LOCK_EN
    logic [N_CH-1:0]      in_last;
`endif
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic [SEL_W-1:0]     out_ch;
    logic                 out_ready;
    logic                 sel_err;

    // Environment side: producers, consumer and mode control.
    modport master (
`ifdef ARB_LOCK_EN
        output in_last,
`endif
        output mode,
        output sel,
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready,
        input  sel_err
    );

    // Mux side.
    modport slave (
`ifdef ARB_LOCK_EN
        input  in_last,
`endif
        input  mode,
        input  sel,
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready,
        output sel_err
    );

endinterface

// File: rtl/rr_arb_mux_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Grants the first requesting
// index found when scanning ptr, ptr+1, ... modulo N_CH.
module rr_pick #(
    parameter  int unsigned N_CH  = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        int unsigned w_k;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_k       = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_k = (32'(ptr) + i) % N_CH;
            if (!gnt_valid && req[w_k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH-channel, W-bit registered mux with per-channel valid/ready.
// Channel chosen by round-robin (mode=0) or by sel (mode=1); one-deep output
// register gives full throughput while out_ready is held high.
// Optional macro ARB_LOCK_EN: adds in_last and keeps round-robin grant on one
// channel until its last beat so multi-beat packets are not interleaved.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = DEF_N_CH,
    parameter  int unsigned W     = DEF_W,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_mux_if.slave   bus
);

    logic             w_load;
    logic             w_xfer;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_sel_ok;
    logic             w_sel_hit;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [W-1:0]     w_gnt_data;

    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic [SEL_W-1:0] r_rr_ptr;
    logic             r_sel_err;

`ifdef ARB_LOCK_EN
    lock_e            r_lock;
    logic [SEL_W-1:0] r_lock_ch;
    logic             w_last;
`endif

    rr_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .req       (bus.in_valid),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Decode sel against the real channel set; non-power-of-two N_CH leaves
    // sel codes with no channel behind them.
    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_hit = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                w_sel_ok  = 1'b1;
                w_sel_hit = bus.in_valid[i];
            end
        end
    end

    // Pick the granted channel for the current mode.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        if (bus.mode == MODE_SEL) begin
            w_gnt_valid = w_sel_hit;
            w_gnt_idx   = bus.sel;
        end
`ifdef ARB_LOCK_EN
        else if (r_lock == LOCK_HELD) begin
            w_gnt_valid = bus.in_valid[r_lock_ch];
            w_gnt_idx   = r_lock_ch;
        end
`endif
        else begin
            w_gnt_valid = w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end
    end

    // Select the granted channel's data word.
    always_comb begin
        w_gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_gnt_data = bus.in_data[i*W +: W];
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign w_last = bus.in_last[w_gnt_idx];
`endif

    // rst_n gates the transfer so no channel sees ready while reset is held,
    // even though the empty output register would otherwise accept.
    assign w_load = !r_out_valid || bus.out_ready;
    assign w_xfer = rst_n && w_load && w_gnt_valid;

    // One-hot ready to the granted channel when the output register can load.
    always_comb begin
        bus.in_ready = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            bus.in_ready[i] = w_xfer && (w_gnt_idx == SEL_W'(i));
        end
    end

    // Output register, round-robin pointer, sel error flag and packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
            r_sel_err   <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock      <= LOCK_FREE;
            r_lock_ch   <= '0;
`endif
        end else begin
            r_sel_err <= (bus.mode == MODE_SEL) && !w_sel_ok;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                if (bus.mode == MODE_RR) begin
`ifdef ARB_LOCK_EN
                    r_lock    <= w_last ? LOCK_FREE : LOCK_HELD;
                    r_lock_ch <= w_gnt_idx;
                    if (w_last) begin
                        r_rr_ptr <= SEL_W'(wrap_inc(32'(w_gnt_idx), N_CH));
                    end
`else
                    r_rr_ptr <= SEL_W'(wrap_inc(32'(w_gnt_idx), N_CH));
`endif
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed and random checks of rr_arb_mux (N_CH=4, W=8) against
// a distance-based arbitration model; a second N_CH=3 instance covers sel_err.
module tb_rr_arb_mux;
    import rr_arb_mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.N_CH(4), .W(8)) bus  ();
    rr_arb_mux_if #(.N_CH(3), .W(8)) bus3 ();

    rr_arb_mux #(.N_CH(4), .W(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    rr_arb_mux #(.N_CH(3), .W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int       m_ptr;
    bit       m_ov;
    bit [7:0] m_od;
    int       m_och;
    bit       m_err;
    bit       m_lock;
    int       m_lock_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Granted channel, or -1: round-robin picks the valid channel nearest
    // at or after the pointer (cyclic distance).
    function automatic int model_grant();
        int best  = -1;
        int bestd = N;
        int d;
        if (bus.mode == MODE_SEL)
            return (int'(bus.sel) < N && bus.in_valid[bus.sel]) ? int'(bus.sel) : -1;
        if (m_lock)
            return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int c = 0; c < N; c++) begin
            d = (c - m_ptr + N) % N;
            if (bus.in_valid[c] && d < bestd) begin
                best  = c;
                bestd = d;
            end
        end
        return best;
    endfunction

    // One clock of the 4-channel DUT, checked before and after the edge.
    task automatic cycle();
        int         g;
        bit         load;
        logic [3:0] e_rdy;
        bit         last;
        #1;
        load  = !m_ov || bus.out_ready;
        g     = model_grant();
        e_rdy = '0;
        if (load && g >= 0) e_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
        @(posedge clk);
        m_err = (bus.mode == MODE_SEL) && int'(bus.sel) >= N;
        if (load && g >= 0) begin
            m_ov  = 1'b1;
            m_od  = bus.in_data[g*W +: W];
            m_och = g;
            if (bus.mode == MODE_RR) begin
                last = 1'b1;
`ifdef ARB_LOCK_EN
                last      = bus.in_last[g];
                m_lock    = !last;
                m_lock_ch = g;
`endif
                if (last) m_ptr = (g + 1) % N;
            end
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) chk("out_data", 32'(bus.out_data), 32'(m_od));
        if (m_ov) chk("out_ch", 32'(bus.out_ch), 32'(m_och));
        chk("sel_err", 32'(bus.sel_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_ptr  = 0;  m_ov = 1'b0; m_od = '0; m_och = 0; m_err = 1'b0;
        m_lock = 1'b0; m_lock_ch = 0;
    endtask

    initial begin
        int seq_a[5];
        int seq_b[4];
        seq_a = '{0, 1, 2, 3, 0};
        seq_b = '{0, 1, 2, 0};

        bus.mode = MODE_RR;  bus.sel = '0;  bus.in_valid = 4'hF;
        bus.in_data = 32'hA3A2A1A0;  bus.out_ready = 1'b1;
        bus3.mode = MODE_RR; bus3.sel = '0; bus3.in_valid = '0;
        bus3.in_data = 24'hC2C1C0;   bus3.out_ready = 1'b1;
`ifdef ARB_LOCK_EN
        bus.in_last = 4'hF;  bus3.in_last = 3'h7;
`endif

        // reset with all channels requesting, then release
        do_reset();

        // round-robin fairness, 1 beat/cycle, first beat from ch0
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq_ch", 32'(bus.out_ch), 32'(seq_a[i]));
            chk("rr_seq_data", 32'(bus.out_data), 32'(8'hA0 + seq_a[i]));
        end

        // wrap/skip: drive pointer to 3 via ch2, then only ch0/ch2 request
        bus.in_valid = 4'b0100;
        cycle();
        chk("skip_pre", 32'(bus.out_ch), 32'd2);
        bus.in_valid = 4'b0101;
        cycle(); chk("wrap_ch0", 32'(bus.out_ch), 32'd0);
        cycle(); chk("skip_ch2", 32'(bus.out_ch), 32'd2);
        cycle(); chk("wrap_ch0b", 32'(bus.out_ch), 32'd0);

        // backpressure: beat from ch0 (A0) must hold for 3 stalled cycles
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_data", 32'(bus.out_data), 32'hA0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1 chk("unstall_ready", 32'(bus.in_ready), 32'h2);
        cycle();
        chk("unstall_ch", 32'(bus.out_ch), 32'd1);

        // explicit select: only ch2, pointer (now 2) untouched
        bus.mode = MODE_SEL;
        bus.sel  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sel_ch", 32'(bus.out_ch), 32'd2);
        end
        bus.mode = MODE_RR;
        cycle();
        chk("sel_ptr_kept", 32'(bus.out_ch), 32'd2);
        cycle();
        chk("sel_ptr_next", 32'(bus.out_ch), 32'd3);

        // N_CH=3 instance: out-of-range sel, in-range sel, then round-robin
        bus3.mode = MODE_SEL; bus3.sel = 2'd3; bus3.in_valid = 3'h7;
        #1 chk("n3_bad_ready", 32'(bus3.in_ready), 32'd0);
        cycle();
        chk("n3_sel_err", 32'(bus3.sel_err), 32'd1);
        chk("n3_no_grant", 32'(bus3.out_valid), 32'd0);
        bus3.sel = 2'd2;
        #1 chk("n3_sel_ready", 32'(bus3.in_ready), 32'h4);
        cycle();
        chk("n3_sel_ch", 32'(bus3.out_ch), 32'd2);
        chk("n3_sel_data", 32'(bus3.out_data), 32'hC2);
        chk("n3_sel_err_clr", 32'(bus3.sel_err), 32'd0);
        bus3.mode = MODE_RR;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("n3_rr_ch", 32'(bus3.out_ch), 32'(seq_b[i]));
        end
        bus3.in_valid = '0;

        // reset with a stalled beat pending: beat dropped, restart at ch0
        bus.out_ready = 1'b0;
        cycle();
        do_reset();
        bus.out_ready = 1'b1;
        cycle();
        chk("post_rst_ch", 32'(bus.out_ch), 32'd0);

`ifdef ARB_LOCK_EN
        // ch1 sends 3 beats (last on the third) while ch2 also requests
        bus.in_valid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = {8'hD0, 8'hD0, 8'(8'hB0 + i), 8'h00};
            bus.in_last = (i == 2) ? 4'b0110 : 4'b0100;
            cycle();
            chk("lock_ch1", 32'(bus.out_ch), 32'd1);
            chk("lock_data", 32'(bus.out_data), 32'(8'hB0 + i));
        end
        cycle();
        chk("lock_release_ch2", 32'(bus.out_ch), 32'd2);
`endif

        // randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            bus.mode      = ($urandom_range(0, 3) == 0) ? MODE_SEL : MODE_RR;
            bus.sel       = 2'($urandom_range(0, 3));
            bus.in_valid  = 4'($urandom_range(0, 15));
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
            bus.in_last   = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
